// File: rtl/hier_evt_pkg.sv
// Shared types and helpers for the hierarchical event collector.
package hier_evt_pkg;

    localparam int unsigned N_CHILD_DEF = 15;

    typedef logic [$clog2(N_CHILD_DEF)-1:0] idx_t;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/hier_rr_pick.sv
// Combinational round-robin find-first: lowest set request at or above ptr_i, else lowest overall.
module hier_rr_pick
    import hier_evt_pkg::*;
#(
    parameter int unsigned N     = N_CHILD_DEF,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Two ascending passes: the upper segment first, then the wrapped lower segment.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_o && req_i[i] && (i >= 32'(ptr_i))) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_o && req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hier_event_collector.sv
// Collects per-child event pulses into a pending bitmap and serializes them as child indices.
// Optional saturating overrun counter enabled by defining HIER_EVT_OVERRUN_CNT_EN.
module hier_event_collector
    import hier_evt_pkg::*;
#(
    parameter int unsigned N_CHILD = N_CHILD_DEF
`ifdef HIER_EVT_OVERRUN_CNT_EN
    ,
    parameter int unsigned CNT_W = 8
`endif
    ,
    localparam int unsigned IDX_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CHILD-1:0] evt_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [IDX_W-1:0]   out_idx_o,
    output logic [N_CHILD-1:0] pending_o,
    output logic               overrun_o
`ifdef HIER_EVT_OVERRUN_CNT_EN
    ,
    output logic [CNT_W-1:0]   ovr_cnt_o
`endif
);

    out_state_e         state_q, state_d;
    logic [N_CHILD-1:0] pending_q, pending_d;
    logic [N_CHILD-1:0] clr_mask;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               overrun_q, overrun_d;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               load;

    hier_rr_pick #(
        .N     (N_CHILD),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (pending_q),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        rr_ptr_d  = rr_ptr_q;
        load      = 1'b0;
        clr_mask  = '0;

        case (state_q)
            OUT_EMPTY: begin
                if (pick_found) begin
                    load    = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready_i) begin
                    if (pick_found) load = 1'b1;
                    else            state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase

        if (load) begin
            out_idx_d          = pick_idx;
            rr_ptr_d           = IDX_W'(next_idx(32'(pick_idx), N_CHILD));
            clr_mask[pick_idx] = 1'b1;
        end

        // A new event on the child being loaded re-sets its bit and is not an overrun.
        pending_d = (pending_q & ~clr_mask) | evt_i;
        overrun_d = |(evt_i & pending_q & ~clr_mask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= OUT_EMPTY;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            out_idx_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            out_idx_q <= out_idx_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid_o = (state_q == OUT_FULL);
    assign out_idx_o   = out_idx_q;
    assign pending_o   = pending_q;
    assign overrun_o   = overrun_q;

`ifdef HIER_EVT_OVERRUN_CNT_EN
    logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_d && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovr_cnt_q <= '0;
        else        ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovr_cnt_o = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_hier_event_collector.sv
// Randomized and directed bench for hier_event_collector against a cycle-level behavioural model.
module tb_hier_event_collector;
    import hier_evt_pkg::*;

    localparam int unsigned NC = N_CHILD_DEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] evt_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [3:0]    out_idx_o;
    logic [NC-1:0] pending_o;
    logic          overrun_o;
`ifdef HIER_EVT_OVERRUN_CNT_EN
    logic [7:0]    ovr_cnt_o;
`endif

    hier_event_collector #(
        .N_CHILD (NC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .evt_i       (evt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_idx_o   (out_idx_o),
        .pending_o   (pending_o),
        .overrun_o   (overrun_o)
`ifdef HIER_EVT_OVERRUN_CNT_EN
        ,
        .ovr_cnt_o   (ovr_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference state: set of pending children, output slot, rotating priority start.
    bit            m_pend [NC];
    bit            m_full;
    int unsigned   m_idx;
    int unsigned   m_ptr;
    bit            m_ovr;
    int unsigned   m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v = '0;
        for (int k = 0; k < NC; k++) if (m_pend[k]) v = v | (32'd1 << k);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) m_pend[k] = 1'b0;
        m_full = 0; m_idx = 0; m_ptr = 0; m_ovr = 0; m_cnt = 0;
    endtask

    task automatic model_update(input logic rst, input logic [NC-1:0] evt, input logic rdy);
        bit          found = 0;
        int unsigned pick  = 0;
        bit          take;
        bit          ovr   = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int unsigned i = 0; i < NC; i++) begin
            int unsigned c = (m_ptr + i) % NC;
            if (!found && m_pend[c]) begin found = 1; pick = c; end
        end
        take = found && (!m_full || rdy);
        for (int k = 0; k < NC; k++)
            if (evt[k] && m_pend[k] && !(take && pick == k)) ovr = 1;
        if (m_full && rdy && !found) m_full = 0;
        if (take) begin
            m_full = 1; m_idx = pick; m_pend[pick] = 0; m_ptr = (pick + 1) % NC;
        end
        for (int k = 0; k < NC; k++) if (evt[k]) m_pend[k] = 1;
        m_ovr = ovr;
        if (ovr && m_cnt < 255) m_cnt++;
    endtask

    // Check registered outputs against the model, then apply inputs for one clock.
    task automatic step(input logic rst, input logic [NC-1:0] evt, input logic rdy);
        check("valid", {31'd0, out_valid_o}, {31'd0, m_full});
        if (m_full) check("idx", {28'd0, out_idx_o}, m_idx);
        check("pending", {17'd0, pending_o}, m_pend_vec());
        check("overrun", {31'd0, overrun_o}, {31'd0, m_ovr});
`ifdef HIER_EVT_OVERRUN_CNT_EN
        check("ovr_cnt", {24'd0, ovr_cnt_o}, m_cnt);
`endif
        rst_n = rst; evt_i = evt; out_ready_i = rdy;
        model_update(rst, evt, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NC-1:0] r_evt;

        // Reset held with every event input active.
        rst_n = 1'b0; evt_i = '1; out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("rst_pend", {17'd0, pending_o}, 32'd0);
        check("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_ovr", {31'd0, overrun_o}, 32'd0);
        check("rst_idx", {28'd0, out_idx_o}, 32'd0);
        step(1, '0, 1);
        check("rel_pend", {17'd0, pending_o}, 32'd0);
        check("rel_valid", {31'd0, out_valid_o}, 32'd0);

        // Single event, two-edge latency.
        step(0, '0, 0);
        step(1, 15'h0008, 1);
        check("t2_pend", {17'd0, pending_o}, 32'h8);
        check("t2_v0", {31'd0, out_valid_o}, 32'd0);
        step(1, '0, 1);
        check("t2_v1", {31'd0, out_valid_o}, 32'd1);
        check("t2_idx", {28'd0, out_idx_o}, 32'd3);
        check("t2_pend0", {17'd0, pending_o}, 32'd0);
        step(1, '0, 1);
        check("t2_vdrop", {31'd0, out_valid_o}, 32'd0);

        // All children at once: strict ascending order, one per cycle.
        step(0, '0, 0);
        step(1, 15'h7FFF, 1);
        for (int i = 0; i < NC; i++) begin
            step(1, '0, 1);
            check("t3_valid", {31'd0, out_valid_o}, 32'd1);
            check("t3_idx", {28'd0, out_idx_o}, 32'(i));
        end
        step(1, '0, 1);
        check("t3_vdrop", {31'd0, out_valid_o}, 32'd0);

        // Backpressure holds the index.
        step(0, '0, 0);
        step(1, 15'h0220, 0);
        step(1, '0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, '0, 0);
            check("t4_hold", {28'd0, out_idx_o}, 32'd5);
        end
        step(1, '0, 1);
        check("t4_idx9", {28'd0, out_idx_o}, 32'd9);
        step(1, '0, 1);
        check("t4_vdrop", {31'd0, out_valid_o}, 32'd0);

        // Overrun while idx 7 is held.
        step(0, '0, 0);
        step(1, 15'h0080, 0);
        step(1, '0, 0);
        check("t5_idx7", {28'd0, out_idx_o}, 32'd7);
        step(1, 15'h0004, 0);
        check("t5_ovr0", {31'd0, overrun_o}, 32'd0);
        step(1, 15'h0004, 0);
        check("t5_ovr1", {31'd0, overrun_o}, 32'd1);
        step(1, '0, 0);
        check("t5_ovr_end", {31'd0, overrun_o}, 32'd0);
        step(1, '0, 1);
        check("t5_idx2", {28'd0, out_idx_o}, 32'd2);
        step(1, '0, 1);
        check("t5_once", {31'd0, out_valid_o}, 32'd0);
`ifdef HIER_EVT_OVERRUN_CNT_EN
        check("t5_cnt", {24'd0, ovr_cnt_o}, 32'd1);
`endif

        // Pointer wrap and re-event on the load cycle.
        step(0, '0, 0);
        step(1, 15'h2000, 1);
        step(1, '0, 1);
        check("t6_idx13", {28'd0, out_idx_o}, 32'd13);
        step(1, 15'h4001, 0);
        step(1, 15'h4000, 1);
        check("t6_idx14", {28'd0, out_idx_o}, 32'd14);
        check("t6_pend", {17'd0, pending_o}, 32'h4001);
        check("t6_noovr", {31'd0, overrun_o}, 32'd0);
        step(1, '0, 1);
        check("t6_idx0", {28'd0, out_idx_o}, 32'd0);
        step(1, '0, 1);
        check("t6_idx14b", {28'd0, out_idx_o}, 32'd14);
        step(1, '0, 1);
        check("t6_vdrop", {31'd0, out_valid_o}, 32'd0);

        // Sustained overruns to drive the counter into saturation.
        step(0, '0, 0);
        for (int i = 0; i < 300; i++) step(1, '1, 0);
        step(1, '0, 1);

        // Random traffic with occasional resets.
        step(0, '0, 0);
        for (int n = 0; n < 2000; n++) begin
            r_evt = '0;
            for (int k = 0; k < NC; k++) if ($urandom_range(0, 5) == 0) r_evt[k] = 1'b1;
            step(($urandom_range(0, 199) != 0), r_evt, ($urandom_range(0, 3) != 0));
        end
        step(1, '0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
